// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding, field widths,
// R/W bit polarity and the address compare helper.
package i2c_pkg;

   localparam int   I2C_ADDR_W  = 7;
   localparam int   I2C_BYTE_W  = 8;
   localparam logic I2C_RW_READ = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_WR_DATA,
      S_WR_ACK,
      S_RD_DATA,
      S_RD_ACK,
      S_WAIT_STOP
   } i2c_tgt_state_t;

   // Upper seven bits of the first byte after START carry the target address.
   function automatic logic addr_match(input logic [I2C_BYTE_W-1:0] addr_byte,
                                       input logic [I2C_ADDR_W-1:0] own_addr);
      return addr_byte[I2C_BYTE_W-1:1] == own_addr;
   endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one raw pad line (SCL or SDA) into a clean level in the clk domain.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter (+2 clk latency).
module i2c_line_cond (
   input  logic clk,
   input  logic rst_n,
   input  logic line_i,
   output logic line_o
);

   logic [1:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[0], line_i};
   end

   // NOTE: flops reset to 1 because an idle I2C bus is pulled high; resetting
   // to 0 would fake an edge on every reset release.
   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= sync_d;
      end
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic [1:0] hist_q, hist_d;
   logic       filt_q, filt_d;

   // Majority of the newest synchronized sample and the two before it.
   always_comb begin
      hist_d = {hist_q[0], sync_q[1]};
      filt_d = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= 2'b11;
         filt_q <= 1'b1;
      end else begin
         hist_q <= hist_d;
         filt_q <= filt_d;
      end
   end

   assign line_o = filt_q;
`else
   assign line_o = sync_q[1];
`endif

endmodule

// File: rtl/i2c_target.sv
// I2C target answering a fixed 7-bit address: write bytes to rx_data/rx_valid, read
// bytes from tx_data/tx_ack. I2C_TARGET_GLITCH_FILTER_EN enables the input glitch filter.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] ADDR = 7'h2A
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  scl_i,
   input  logic                  sda_i,
   output logic                  sda_oe,
   output logic [I2C_BYTE_W-1:0] rx_data,
   output logic                  rx_valid,
   input  logic [I2C_BYTE_W-1:0] tx_data,
   output logic                  tx_ack,
   output logic                  addr_hit,
   output logic                  busy
);

   logic scl_s, sda_s;

   i2c_line_cond u_scl_cond (
      .clk    (clk),
      .rst_n  (rst_n),
      .line_i (scl_i),
      .line_o (scl_s)
   );

   i2c_line_cond u_sda_cond (
      .clk    (clk),
      .rst_n  (rst_n),
      .line_i (sda_i),
      .line_o (sda_s)
   );

   // Edge/condition detection, registered so sda_prev_q lines up with each event.
   logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
   logic scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
   logic start_q, start_d, stop_q, stop_d;

   always_comb begin
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
      scl_rise_d = scl_s & ~scl_prev_q;
      scl_fall_d = ~scl_s & scl_prev_q;
      start_d    = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
      stop_d     = scl_s & scl_prev_q & sda_s & ~sda_prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         scl_rise_q <= 1'b0;
         scl_fall_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
         scl_rise_q <= scl_rise_d;
         scl_fall_q <= scl_fall_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
      end
   end

   i2c_tgt_state_t          state_q, state_d;
   logic [3:0]              bit_cnt_q, bit_cnt_d;
   logic [I2C_BYTE_W-1:0]   shift_q, shift_d;
   logic                    rw_q, rw_d;
   logic                    sda_oe_q, sda_oe_d;
   logic [I2C_BYTE_W-1:0]   rx_data_q, rx_data_d;
   logic                    rx_valid_q, rx_valid_d;
   logic                    tx_ack_q, tx_ack_d;
   logic                    addr_hit_q, addr_hit_d;
   logic                    busy_q, busy_d;
   logic                    do_load;
   logic [I2C_BYTE_W-1:0]   shift_in;

   assign shift_in = {shift_q[I2C_BYTE_W-2:0], sda_prev_q};

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rw_d       = rw_q;
      sda_oe_d   = sda_oe_q;
      rx_data_d  = rx_data_q;
      busy_d     = busy_q;
      rx_valid_d = 1'b0;
      tx_ack_d   = 1'b0;
      addr_hit_d = 1'b0;
      do_load    = 1'b0;

      if (start_q) begin
         state_d   = S_ADDR;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else if (stop_q) begin
         state_d   = S_IDLE;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: ;
            S_ADDR: begin
               if (scl_rise_q) begin
                  shift_d = shift_in;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = 4'd0;
                     if (addr_match(shift_in, ADDR)) begin
                        addr_hit_d = 1'b1;
                        rw_d       = shift_in[0];
                        busy_d     = 1'b1;
                        state_d    = S_ADDR_ACK;
                     end else begin
                        state_d = S_WAIT_STOP;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            // First fall opens the ACK window, second fall closes it.
            S_ADDR_ACK: begin
               if (scl_fall_q) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else if (rw_q == I2C_RW_READ) begin
                     do_load = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = S_WR_DATA;
                  end
               end
            end
            S_WR_DATA: begin
               if (scl_rise_q) begin
                  shift_d = shift_in;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d  = 4'd0;
                     rx_data_d  = shift_in;
                     rx_valid_d = 1'b1;
                     state_d    = S_WR_ACK;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            S_WR_ACK: begin
               if (scl_fall_q) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = S_WR_DATA;
                  end
               end
            end
            S_RD_DATA: begin
               if (scl_fall_q) begin
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = 4'd0;
                     sda_oe_d  = 1'b0;
                     state_d   = S_RD_ACK;
                  end else begin
                     shift_d   = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                     sda_oe_d  = ~shift_q[I2C_BYTE_W-2];
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            // bit_cnt doubles as the "controller ACKed" flag between rise and fall.
            S_RD_ACK: begin
               if (scl_rise_q && bit_cnt_q == 4'd0) begin
                  if (sda_prev_q) begin
                     busy_d  = 1'b0;
                     state_d = S_WAIT_STOP;
                  end else begin
                     bit_cnt_d = 4'd1;
                  end
               end else if (scl_fall_q && bit_cnt_q == 4'd1) begin
                  do_load = 1'b1;
               end
            end
            S_WAIT_STOP: ;
            default: state_d = S_IDLE;
         endcase

         if (do_load) begin
            shift_d   = tx_data;
            tx_ack_d  = 1'b1;
            sda_oe_d  = ~tx_data[I2C_BYTE_W-1];
            bit_cnt_d = 4'd0;
            state_d   = S_RD_DATA;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= '0;
         rw_q       <= 1'b0;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_ack_q   <= 1'b0;
         addr_hit_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rw_q       <= rw_d;
         sda_oe_q   <= sda_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_ack_q   <= tx_ack_d;
         addr_hit_q <= addr_hit_d;
         busy_q     <= busy_d;
      end
   end

   assign sda_oe   = sda_oe_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_ack   = tx_ack_q;
   assign addr_hit = addr_hit_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: table of write transactions plus hand-written
// read, repeated-START, reset-mid-read and SCL-spike sequences.
module tb_i2c_target;
   import i2c_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_c = 1'b1;
   logic       sda_c = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       sda_oe, rx_valid, tx_ack, addr_hit, busy;
   logic [7:0] rx_data;
   logic       sda_line;

   // Open-drain bus: either side may pull SDA low.
   assign sda_line = sda_c & ~sda_oe;

   i2c_target dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .scl_i    (scl_c),
      .sda_i    (sda_line),
      .sda_oe   (sda_oe),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_ack   (tx_ack),
      .addr_hit (addr_hit),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int hit_cnt = 0, rxv_cnt = 0, txa_cnt = 0, oe_cnt = 0;
   always @(posedge clk) begin
      hit_cnt <= hit_cnt + int'(addr_hit);
      rxv_cnt <= rxv_cnt + int'(rx_valid);
      txa_cnt <= txa_cnt + int'(tx_ack);
      oe_cnt  <= oe_cnt + int'(sda_oe);
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Quarter SCL period: 8 clk, so fclk = 32 x fSCL.
   task automatic wait_q();
      repeat (8) @(negedge clk);
   endtask

   task automatic bit_tx(input logic b, input bit spike, output logic seen);
      wait_q();
      sda_c = b;
      wait_q();
      scl_c = 1'b1;
      wait_q();
      seen = sda_line;
      if (spike) begin
         scl_c = 1'b0;
         @(negedge clk);
         scl_c = 1'b1;
      end
      wait_q();
      scl_c = 1'b0;
   endtask

   task automatic start_cond();
      wait_q();
      sda_c = 1'b1;
      wait_q();
      scl_c = 1'b1;
      wait_q();
      sda_c = 1'b0;
      wait_q();
      scl_c = 1'b0;
   endtask

   task automatic stop_cond();
      wait_q();
      sda_c = 1'b0;
      wait_q();
      scl_c = 1'b1;
      wait_q();
      sda_c = 1'b1;
      wait_q();
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] d, input int spike_bit, output logic ack);
      logic dummy;
      for (int i = 7; i >= 0; i--) bit_tx(d[i], i == spike_bit, dummy);
      bit_tx(1'b1, 1'b0, ack);
   endtask

   task automatic read_byte(input logic ack_bit, output logic [7:0] d);
      logic dummy;
      for (int i = 7; i >= 0; i--) bit_tx(1'b1, 1'b0, d[i]);
      bit_tx(ack_bit, 1'b0, dummy);
   endtask

   typedef struct {
      logic [7:0] addr_b;
      logic [7:0] data_b;
      logic       exp_aack;   // 0 = ACK seen on the bus
      logic       exp_dack;
      int         exp_hit;
      int         exp_rxv;
      logic [7:0] exp_rx;
      logic       exp_oe;
   } wr_vec_t;

   wr_vec_t vecs[5];

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic       a_ack, d_ack, busy_mid;
      logic [7:0] rd0, rd1;
      int         hb, rb, tb, ob;

      vecs[0] = '{8'h54, 8'h55, 1'b0, 1'b0, 1, 1, 8'h55, 1'b1};
      vecs[1] = '{8'h56, 8'hFF, 1'b1, 1'b1, 0, 0, 8'h55, 1'b0};
      vecs[2] = '{8'h54, 8'h00, 1'b0, 1'b0, 1, 1, 8'h00, 1'b1};
      vecs[3] = '{8'h54, 8'hFF, 1'b0, 1'b0, 1, 1, 8'hFF, 1'b1};
      vecs[4] = '{8'hAA, 8'h12, 1'b1, 1'b1, 0, 0, 8'hFF, 1'b0};

      repeat (4) @(negedge clk);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_rx_data", 32'(rx_data), 32'h00);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_tx_ack", 32'(tx_ack), 32'd0);
      check("rst_addr_hit", 32'(addr_hit), 32'd0);
      check("rst_state", 32'(dut.state_q), 32'(S_IDLE));

      for (int i = 0; i < 5; i++) begin
         hb = hit_cnt; rb = rxv_cnt; ob = oe_cnt;
         start_cond();
         write_byte(vecs[i].addr_b, -1, a_ack);
         write_byte(vecs[i].data_b, -1, d_ack);
         busy_mid = busy;
         stop_cond();
         check($sformatf("wr%0d_addr_ack", i), 32'(a_ack), 32'(vecs[i].exp_aack));
         check($sformatf("wr%0d_data_ack", i), 32'(d_ack), 32'(vecs[i].exp_dack));
         check($sformatf("wr%0d_addr_hit", i), 32'(hit_cnt - hb), 32'(vecs[i].exp_hit));
         check($sformatf("wr%0d_rx_valid", i), 32'(rxv_cnt - rb), 32'(vecs[i].exp_rxv));
         check($sformatf("wr%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
         check($sformatf("wr%0d_busy_mid", i), 32'(busy_mid), 32'(vecs[i].exp_hit));
         check($sformatf("wr%0d_busy_end", i), 32'(busy), 32'd0);
         check($sformatf("wr%0d_oe_seen", i), 32'(ob != oe_cnt), 32'(vecs[i].exp_oe));
         check($sformatf("wr%0d_state", i), 32'(dut.state_q), 32'(S_IDLE));
      end

      // Read two bytes: ACK the first, NACK the second.
      tx_data = 8'hA5;
      tb = txa_cnt;
      start_cond();
      write_byte(8'h55, -1, a_ack);
      check("rd_addr_ack", 32'(a_ack), 32'd0);
      for (int k = 0; k < 100 && txa_cnt == tb; k++) @(negedge clk);
      check("rd_first_tx_ack", 32'(txa_cnt - tb), 32'd1);
      tx_data = 8'h3C;
      read_byte(1'b0, rd0);
      read_byte(1'b1, rd1);
      ob = oe_cnt;
      stop_cond();
      check("rd_byte0", 32'(rd0), 32'hA5);
      check("rd_byte1", 32'(rd1), 32'h3C);
      check("rd_tx_ack_total", 32'(txa_cnt - tb), 32'd2);
      check("rd_no_oe_after_nack", 32'(oe_cnt - ob), 32'd0);
      check("rd_busy_end", 32'(busy), 32'd0);

      // Write then repeated START into a one-byte read.
      tx_data = 8'h96;
      hb = hit_cnt;
      start_cond();
      write_byte(8'h54, -1, a_ack);
      write_byte(8'h11, -1, d_ack);
      check("sr_data_ack", 32'(d_ack), 32'd0);
      start_cond();
      write_byte(8'h55, -1, a_ack);
      check("sr_read_addr_ack", 32'(a_ack), 32'd0);
      read_byte(1'b1, rd0);
      stop_cond();
      check("sr_rx_data", 32'(rx_data), 32'h11);
      check("sr_read_byte", 32'(rd0), 32'h96);
      check("sr_addr_hits", 32'(hit_cnt - hb), 32'd2);

      // Reset while the target drives the first read bit low.
      tx_data = 8'h00;
      start_cond();
      write_byte(8'h55, -1, a_ack);
      repeat (10) @(negedge clk);
      check("rr_oe_before_reset", 32'(sda_oe), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rr_oe_in_reset", 32'(sda_oe), 32'd0);
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      stop_cond();
      check("rr_state_after", 32'(dut.state_q), 32'(S_IDLE));
      rb = rxv_cnt;
      start_cond();
      write_byte(8'h54, -1, a_ack);
      write_byte(8'h77, -1, d_ack);
      stop_cond();
      check("rr_addr_ack", 32'(a_ack), 32'd0);
      check("rr_data_ack", 32'(d_ack), 32'd0);
      check("rr_rx_data", 32'(rx_data), 32'h77);
      check("rr_rx_valid", 32'(rxv_cnt - rb), 32'd1);

      // One-clk SCL low spike during the MSB of a write data byte.
      rb = rxv_cnt;
      start_cond();
      write_byte(8'h54, -1, a_ack);
      write_byte(8'h55, 7, d_ack);
      stop_cond();
      check("sp_rx_valid", 32'(rxv_cnt - rb), 32'd1);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
      check("sp_rx_data", 32'(rx_data), 32'h55);
      check("sp_data_ack", 32'(d_ack), 32'd0);
`else
      // Extra rise re-shifts the MSB: {0,0,1,0,1,0,1,0}.
      check("sp_rx_data", 32'(rx_data), 32'h2A);
`endif
      check("sp_state", 32'(dut.state_q), 32'(S_IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
